fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 197 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- instruction fetch front end.
//
// Keeps a fetch PC and issues word requests to instruction memory. It buffers
// in-order responses as {pc, instr} pairs in a 2-entry FIFO. Each cycle that
// decode is not stalled, it hands one pair (or a NOP bubble) to decode. A
// redirect from execute flushes the FIFO and restarts fetch at a new address.
// Responses to requests that were in flight at the redirect are counted and
// discarded as they return.
//
// Optional feature: define FETCH_MISALIGN_TRAP_EN to flag a redirect to a
// non-word-aligned address. The flag raises misalign and blocks fetch until
// the next aligned redirect. Without the macro, the low two bits of
// redirect_pc are ignored and misalign is tied low.
//
// Parameters
//   RESET_PC     first fetch address after reset
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   stall_d      decode stalled: hold pc_out/instr_out, do not pop
//   redirect     taken branch/jump, priority over stall_d
//   redirect_pc  new fetch address when redirect=1
//   imem_req     request valid (held with imem_addr until imem_gnt)
//   imem_addr    request word address
//   imem_gnt     request accepted this cycle
//   imem_rvalid  in-order response valid
//   imem_rdata   response instruction word
//   pc_out       registered PC to decode
//   instr_out    registered instruction to decode
//   misalign     registered misaligned-redirect flag
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_d,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        misalign
);

    localparam logic [31:0] NOP       = 32'h0000_0013;
    // Ceiling on total in-flight requests, live plus to-be-discarded. It
    // only binds under back-to-back redirects against a slow memory. It
    // keeps the 3-bit counters from wrapping.
    localparam logic [2:0]  OUTST_MAX = 3'd6;

    // Fetch state
    logic [31:0] fetch_pc;     // address of the next request
    logic [31:0] resp_pc;      // pc belonging to the next kept response
    logic        req_hold;     // request raised last cycle but not granted
    logic        halt;         // fetch blocked by misaligned redirect

    // Response FIFO
    logic [31:0] fifo_pc    [0:1];
    logic [31:0] fifo_instr [0:1];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;

    // In-flight tracking
    logic [2:0]  outst;        // granted, response not yet returned
    logic [2:0]  drop;         // of those, responses still to discard
    logic [2:0]  outst_nxt;
    logic [2:0]  live;         // in flight and destined for the FIFO

    logic        fire;
    logic        accept;
    logic        pop;
    logic        credit_ok;
    logic [3:0]  credit;
    logic [31:0] target_pc;
    logic        target_bad;

    // ------------------------------------------------------------------
    // Redirect target handling
    // ------------------------------------------------------------------
`ifdef FETCH_MISALIGN_TRAP_EN
    assign target_pc  = redirect_pc;
    assign target_bad = |redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst)
            halt <= 1'b0;
        else if (redirect)
            halt <= target_bad;
    end

    assign misalign = halt;
`else
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
    assign target_pc  = {redirect_pc[31:2], 2'b00};
    assign target_bad = 1'b0;
    assign halt       = target_bad;
    assign misalign   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    assign live   = outst - drop;
    assign pop    = !redirect && !stall_d && (count != 2'd0);

    // A new request needs a FIFO slot that is free once this cycle's pop is
    // counted. Responses that will be discarded never reach the FIFO, so
    // they do not use a slot. Fetch can therefore restart right after a
    // redirect, even with old responses still pending.
    assign credit    = {2'b00, count} + {1'b0, live};
    assign credit_ok = credit < (4'd2 + {3'b000, pop});

    // Once raised, a request stays up until it is granted. The FIFO-slot
    // count cannot grow while it waits, so holding it up is always safe.
    assign imem_req  = !rst && !halt &&
                       (req_hold || (credit_ok && (outst < OUTST_MAX)));
    assign imem_addr = fetch_pc;
    assign fire      = imem_req && imem_gnt;

    assign outst_nxt = outst + {2'b00, fire} - {2'b00, imem_rvalid};

    // A response arriving in the redirect cycle is discarded with the rest.
    assign accept    = imem_rvalid && (drop == 3'd0) && !redirect;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            resp_pc   <= RESET_PC;
            req_hold  <= 1'b0;
            outst     <= 3'd0;
            drop      <= 3'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            pc_out    <= 32'h0000_0000;
            instr_out <= NOP;
        end else begin
            outst    <= outst_nxt;
            req_hold <= imem_req && !imem_gnt && !redirect;

            // Everything still in flight after this edge belongs to the old path.
            if (redirect)
                drop <= outst_nxt;
            else if (imem_rvalid && (drop != 3'd0))
                drop <= drop - 3'd1;

            if (redirect)
                fetch_pc <= target_pc;
            else if (fire)
                fetch_pc <= fetch_pc + 32'd4;

            // Kept responses return in order for consecutive addresses.
            if (redirect)
                resp_pc <= target_pc;
            else if (accept)
                resp_pc <= resp_pc + 32'd4;

            if (redirect) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (accept) begin
                    fifo_pc[wr_ptr]    <= resp_pc;
                    fifo_instr[wr_ptr] <= imem_rdata;
                    wr_ptr             <= ~wr_ptr;
                end
                if (pop)
                    rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, accept} - {1'b0, pop};
            end

            if (redirect) begin
                instr_out <= NOP;
            end else if (!stall_d) begin
                if (pop) begin
                    pc_out    <= fifo_pc[rd_ptr];
                    instr_out <= fifo_instr[rd_ptr];
                end else begin
                    instr_out <= NOP;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit -- randomized self-checking bench for fetch_unit.
//
// The bench contains a memory that grants and responds in order after a
// chosen latency. It also contains a reference model. The model holds the
// in-flight requests as a queue of {addr, ready, keep} records and the
// decode buffer as a queue of {pc, instr} pairs. A redirect marks every
// in-flight record as not kept. Each cycle the bench checks imem_req and
// imem_addr before the clock edge, and pc_out, instr_out and misalign
// after it.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_d;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        misalign;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall_d(stall_d), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc_out(pc_out), .instr_out(instr_out), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int ready; bit keep; } flight_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    flight_t     fl[$];
    ent_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          last_ready = 0;
    logic [31:0] m_fpc = 32'h0;
    logic [31:0] m_pc_out = 32'h0;
    logic [31:0] m_instr = NOP;
    bit          m_hold = 1'b0;
    bit          m_halt = 1'b0;
    bit          seen_req;
    logic [31:0] seen_addr;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive the inputs, check the request side, advance the
    // model at the edge, then check the registered outputs.
    task automatic cycle(input bit r, input bit st, input bit rd,
                         input logic [31:0] rpc, input bit g, input int lat);
        int      live;
        bit      pop, exp_req, fire, rv;
        flight_t h;
        ent_t    e;
        @(negedge clk);
        rst = r; stall_d = st; redirect = rd; redirect_pc = rpc; imem_gnt = g;
        if (r) rv = ($urandom_range(0, 1) == 1);
        else   rv = (fl.size() > 0) && (fl[0].ready <= cyc);
        imem_rvalid = rv;
        imem_rdata  = (rv && !r) ? word_at(fl[0].addr) : $urandom();
        live = 0;
        foreach (fl[i]) if (fl[i].keep) live++;
        pop = !r && !rd && !st && (q.size() > 0);
        exp_req = !r && !m_halt &&
                  (m_hold || (((q.size() + live - int'(pop)) < 2) && (fl.size() < 6)));
        #1;
        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, m_fpc);
        seen_req  = imem_req;
        seen_addr = imem_addr;
        fire = imem_req && g;
        @(posedge clk);
        if (r) begin
            fl.delete(); q.delete();
            m_fpc = 32'h0; m_pc_out = 32'h0; m_instr = NOP;
            m_hold = 1'b0; m_halt = 1'b0; last_ready = cyc;
        end else begin
            h = '{addr: 32'h0, ready: 0, keep: 1'b0};
            if (rv) h = fl.pop_front();
            if (rd) m_instr = NOP;
            else if (!st) begin
                if (pop) begin
                    e = q.pop_front();
                    m_pc_out = e.pc; m_instr = e.instr;
                end else m_instr = NOP;
            end
            if (rv && h.keep && !rd) begin
                e.pc = h.addr; e.instr = word_at(h.addr);
                q.push_back(e);
            end
            if (q.size() > 2) begin
                checks++; errors++;
                $display("FAIL fifo_overflow cycle=%0d got=%0d want<=2", cyc, q.size());
            end
            if (fire) begin
                last_ready = (cyc + lat > last_ready + 1) ? cyc + lat : last_ready + 1;
                fl.push_back('{addr: m_fpc, ready: last_ready, keep: 1'b1});
            end
            m_hold = exp_req && !g && !rd;
            if (rd) begin
                foreach (fl[i]) fl[i].keep = 1'b0;
                q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
                m_fpc  = rpc;
                m_halt = (rpc % 4) != 0;
`else
                m_fpc  = rpc - (rpc % 4);
`endif
            end else if (fire) m_fpc = m_fpc + 32'd4;
        end
        cyc++;
        #1;
        chk("pc_out", pc_out, m_pc_out);
        chk("instr_out", instr_out, m_instr);
        chk("misalign", {31'b0, misalign}, {31'b0, m_halt});
    endtask

    initial begin
        logic [31:0] rpc;
        rst = 1'b1; stall_d = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

        // Reset, with response noise that must be ignored
        cycle(1, 0, 0, 32'h0, 1, 1);
        cycle(1, 0, 0, 32'h0, 1, 1);
        chk("rst_pc_out", pc_out, 32'h0000_0000);
        chk("rst_instr", instr_out, 32'h0000_0013);

        // Streaming: addresses 0,4,8,... and the first word appears at cycle 3
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 0, 32'h0, 1, 1);
            chk("seq_addr", seen_addr, 32'(i * 4));
            if (i < 2) chk("seq_bubble", instr_out, 32'h0000_0013);
            if (i == 2) chk("first_word", instr_out, 32'h5A5A_FFFF);
            if (i == 3) chk("second_pc", pc_out, 32'h0000_0004);
        end

        // Decode stall for 5 cycles: the request drops once 2 are buffered
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 32'h0, 1, 1);
        chk("stall_req_off", {31'b0, seen_req}, 32'h0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 32'h0, 1, 1);

        // Redirect to 0x100 while 2-cycle memory latency keeps 2 in flight
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 32'h0, 1, 2);
        cycle(0, 0, 1, 32'h0000_0100, 1, 2);
        chk("redir_nop", instr_out, 32'h0000_0013);
        cycle(0, 0, 0, 32'h0, 1, 2);
        chk("redir_addr", seen_addr, 32'h0000_0100);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 32'h0, 1, 2);

        // Grant withheld for 3 cycles
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 32'h0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 32'h0, 1, 1);

        // Misaligned redirect
        cycle(0, 0, 1, 32'h0000_0102, 1, 1);
        cycle(0, 0, 0, 32'h0, 1, 1);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misalign_set", {31'b0, misalign}, 32'h1);
        chk("misalign_noreq", {31'b0, seen_req}, 32'h0);
        cycle(0, 0, 1, 32'h0000_0200, 1, 1);
`else
        chk("misalign_addr", seen_addr, 32'h0000_0100);
`endif
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 32'h0, 1, 1);

        // Wrap of the fetch PC
        cycle(0, 0, 1, 32'hFFFF_FFFC, 1, 1);
        cycle(0, 0, 0, 32'h0, 1, 1);
        chk("wrap_top", seen_addr, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 32'h0, 1, 1);
        chk("wrap_zero", seen_addr, 32'h0000_0000);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 32'h0, 1, 1);

        // Random traffic, including resets in mid-operation
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       rpc = 32'hFFFF_FFF0 + ($urandom_range(0, 3) * 4);
                1:       rpc = $urandom();
                default: rpc = $urandom() & 32'hFFFF_FFFC;
            endcase
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 9) < 3,
                  $urandom_range(0, 19) == 0,
                  rpc,
                  $urandom_range(0, 9) < 7,
                  $urandom_range(1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
